// File: rtl/pll_clk_enable_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_clk_enable_gen_if
// Description : Lock, load/increment and enable-strobe bundle for the
//               fractional clock-enable generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_clk_enable_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 16
);
    logic                      pll_locked;
    logic                      load;
    logic [NUM_CH*ACC_W-1:0]   inc;
    logic [NUM_CH-1:0]         ce;
    logic                      ready;

    modport master (
        output pll_locked,
        output load,
        output inc,
        input  ce,
        input  ready
    );

    modport slave (
        input  pll_locked,
        input  load,
        input  inc,
        output ce,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/pll_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_clk_enable_gen
// Description : Lock-qualified multi-channel fractional clock-enable generator
//               built from per-channel phase accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_clk_enable_gen #(
    parameter int NUM_CH     = 4,
    parameter int ACC_W      = 16,
    parameter int SETTLE_CYC = 16
) (
    input  wire logic            refclk,
    input  wire logic            rst,
    pll_clk_enable_gen_if.slave  bus
);

    localparam logic [1:0] C_WAIT_LOCK = 2'd0;
    localparam logic [1:0] C_SETTLE    = 2'd1;
    localparam logic [1:0] C_RUN       = 2'd2;

    localparam int                 C_CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SETTLE_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic [1:0]               r_sync;
    logic                     w_locked_s;
    logic [1:0]               r_state;
    logic [C_CNT_W-1:0]       r_cnt;
    logic [NUM_CH*ACC_W-1:0]  r_inc;
    logic [NUM_CH-1:0]        w_ce;
    logic                     w_acc_en;

    assign w_locked_s = r_sync[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.pll_locked};
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= C_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                C_WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_locked_s) begin
                        r_state <= C_SETTLE;
                    end
                end
                C_SETTLE: begin
                    if (!w_locked_s) begin
                        r_state <= C_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= C_RUN;
                        end
                    end
                end
                C_RUN: begin
                    if (!w_locked_s) begin
                        r_state <= C_WAIT_LOCK;
                    end
                end
                default: begin
                    r_state <= C_WAIT_LOCK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_inc <= '0;
        end else if (bus.load) begin
            r_inc <= bus.inc;
        end
    end

    // Accumulate only in a RUN cycle that is neither a realign (load) nor the lock-loss edge.
    assign w_acc_en = (r_state == C_RUN) && w_locked_s && !bus.load;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic             r_ce;
        logic [ACC_W:0]   w_sum;

        assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc[gi*ACC_W +: ACC_W]};
        assign w_ce[gi] = r_ce;

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (w_acc_en) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end else begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end
        end
    end

    assign bus.ce    = w_ce;
    assign bus.ready = (r_state == C_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_clk_enable_gen
// Description : Self-checking bench for pll_clk_enable_gen (vector table,
//               randomized increments against an arithmetic rate model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_clk_enable_gen;

    localparam int NUM_CH     = 4;
    localparam int ACC_W      = 16;
    localparam int SETTLE_CYC = 16;
    localparam int C_LAT      = SETTLE_CYC + 3;

    typedef struct {
        logic [NUM_CH*ACC_W-1:0] inc;
        int                      cycles;
        int                      exp_cnt [NUM_CH];
    } vec_t;

    logic refclk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 refclk = ~refclk;

    pll_clk_enable_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

    pll_clk_enable_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Channel k-th strobe after alignment: did floor(k*inc/2^W) step up?
    function automatic logic [NUM_CH-1:0] model_ce(input logic [NUM_CH*ACC_W-1:0] inc, input int k);
        logic [NUM_CH-1:0] m;
        longint unsigned   a;
        longint unsigned   kk;
        kk = longint'(k);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            a     = longint'(inc[ch*ACC_W +: ACC_W]);
            m[ch] = ((a * kk) >> ACC_W) != ((a * (kk - 1)) >> ACC_W);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Caller raises pll_locked just before the first sampling edge.
    task automatic measure_lock(input string name);
        int n;
        int ce_bad;
        bit seen;
        n      = 0;
        ce_bad = 0;
        seen   = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (bus.ce !== '0) ce_bad++;
            if (bus.ready === 1'b1) seen = 1'b1;
        end
        check({name, "_latency"}, n, C_LAT);
        check({name, "_ce_quiet"}, ce_bad, 0);
    endtask

    // Runs N aligned cycles, comparing each strobe against the model and totalling pulses.
    task automatic run_cycles(input string name, input logic [NUM_CH*ACC_W-1:0] inc, input int n,
                              input bit per_cycle, output int cnt [NUM_CH], output int phase_err);
        logic [NUM_CH-1:0] exp_ce;
        phase_err = 0;
        for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            exp_ce = model_ce(inc, k);
            for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] += int'(bus.ce[ch]);
            if (per_cycle) check({name, "_ce"}, longint'(bus.ce), longint'(exp_ce));
            else if (bus.ce !== exp_ce) phase_err++;
        end
    endtask

    task automatic load_inc(input string name, input logic [NUM_CH*ACC_W-1:0] inc);
        bus.inc  = inc;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check({name, "_load_edge_ce"}, longint'(bus.ce), 0);
    endtask

    initial begin
        vec_t              vecs [5];
        int                cnt [NUM_CH];
        int                perr;
        logic [NUM_CH*ACC_W-1:0] rinc;

        vecs[0].inc = {16'hFFFF, 16'h0000, 16'h4000, 16'h8000}; vecs[0].cycles = 16;
        vecs[0].exp_cnt = '{8, 4, 0, 15};
        vecs[1].inc = {16'hFFFF, 16'h0001, 16'h1000, 16'h5556}; vecs[1].cycles = 3000;
        vecs[1].exp_cnt = '{1000, 187, 0, 2999};
        vecs[2].inc = {16'h7FFF, 16'hC000, 16'h0800, 16'h2000}; vecs[2].cycles = 64;
        vecs[2].exp_cnt = '{8, 2, 48, 31};
        vecs[3].inc = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; vecs[3].cycles = 50;
        vecs[3].exp_cnt = '{0, 0, 0, 0};
        vecs[4].inc = {16'h8001, 16'h0100, 16'hAAAA, 16'h3333}; vecs[4].cycles = 100;
        vecs[4].exp_cnt = '{19, 66, 0, 50};

        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.load       = 1'b0;
        bus.inc        = '0;
        repeat (3) tick();
        check("reset_ce", longint'(bus.ce), 0);
        check("reset_ready", longint'(bus.ready), 0);
        rst = 1'b0;
        repeat (5) tick();
        check("unlocked_ready", longint'(bus.ready), 0);

        bus.pll_locked = 1'b1;
        measure_lock("first_lock");

        for (int v = 0; v < 5; v++) begin
            load_inc($sformatf("vec%0d", v), vecs[v].inc);
            run_cycles($sformatf("vec%0d", v), vecs[v].inc, vecs[v].cycles, 1'b0, cnt, perr);
            check($sformatf("vec%0d_phase", v), perr, 0);
            for (int ch = 0; ch < NUM_CH; ch++)
                check($sformatf("vec%0d_count_ch%0d", v, ch), cnt[ch], vecs[v].exp_cnt[ch]);
        end

        for (int r = 0; r < 30; r++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case ($urandom_range(0, 5))
                    0:       rinc[ch*ACC_W +: ACC_W] = 16'h0000;
                    1:       rinc[ch*ACC_W +: ACC_W] = 16'hFFFF;
                    2:       rinc[ch*ACC_W +: ACC_W] = 16'(1 << $urandom_range(0, 15));
                    default: rinc[ch*ACC_W +: ACC_W] = 16'($urandom_range(0, 65535));
                endcase
            end
            load_inc($sformatf("rnd%0d", r), rinc);
            run_cycles($sformatf("rnd%0d", r), rinc, int'($urandom_range(10, 300)), 1'b1, cnt, perr);
        end

        // Lock loss in RUN, with a load landing on the withdrawal edge.
        load_inc("pre_loss", {NUM_CH{16'hFFFF}});
        repeat (5) tick();
        check("pre_loss_ce", longint'(bus.ce), longint'({NUM_CH{1'b1}}));
        bus.pll_locked = 1'b0;
        tick();
        tick();
        check("loss_ready_held", longint'(bus.ready), 1);
        bus.inc  = {NUM_CH{16'h8000}};
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("loss_ready", longint'(bus.ready), 0);
        check("loss_ce", longint'(bus.ce), 0);
        repeat (4) tick();
        check("unlocked_ce", longint'(bus.ce), 0);

        // Glitch during SETTLE restarts qualification.
        bus.pll_locked = 1'b1;
        repeat (12) tick();
        check("settle_ready", longint'(bus.ready), 0);
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        measure_lock("glitch_relock");
        run_cycles("captured_inc", {NUM_CH{16'h8000}}, 16, 1'b0, cnt, perr);
        check("captured_inc_phase", perr, 0);
        check("captured_inc_count", cnt[0] + cnt[1] + cnt[2] + cnt[3], 32);

        // Asynchronous reset between edges.
        @(posedge refclk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ce", longint'(bus.ce), 0);
        check("async_rst_ready", longint'(bus.ready), 0);
        tick();
        rst = 1'b0;
        measure_lock("post_reset");
        run_cycles("post_reset_inc0", '0, 20, 1'b0, cnt, perr);
        check("post_reset_pulses", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
